// File: rtl/mem_cmd_sequencer_pkg.sv
// Shared definitions for the memory command sequencer: memory_unit func codes, widths, request ops, FSM states.
// Optional feature macro used by the sequencer: MEM_TIMEOUT_EN.
package mem_cmd_sequencer_pkg;

   localparam int MEMORY_ADDR_WIDTH = 10;
   localparam int MEMORY_DATA_WIDTH = 64;

   localparam logic [1:0] GET_CONTENTS = 2'd0;
   localparam logic [1:0] SET_CONTENTS = 2'd1;
   localparam logic [1:0] GET_FREE     = 2'd2;

   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_ALLOC = 2'd2;
   localparam logic [1:0] OP_RSVD  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ISSUE     = 3'd1,
      ST_BLIND     = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESP      = 3'd4
   } seq_state_t;

   // First memory command of each request; ALLOC switches to SET_CONTENTS for its second phase.
   function automatic logic [1:0] op_first_func(input logic [1:0] op);
      case (op)
         OP_WRITE: return SET_CONTENTS;
         OP_ALLOC: return GET_FREE;
         default:  return GET_CONTENTS;
      endcase
   endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// WAIT_DONE watchdog for mem_cmd_sequencer; only built when MEM_TIMEOUT_EN is defined.
// Counts cycles while run is high and flags the LIMIT-th consecutive cycle.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] count_q;

   // Held at zero outside the waiting state, so every entry starts a fresh count.
   always_ff @(posedge clk) begin
      if (rst || !run) count_q <= '0;
      else             count_q <= count_q + 1'b1;
   end

   assign expired = run && (count_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_cmd_sequencer.sv
// Single-outstanding initiator for memory_unit: turns READ/WRITE/ALLOC requests into execute/is_ready sequences.
// Optional MEM_TIMEOUT_EN adds a WAIT_DONE watchdog (TIMEOUT_CYCLES) that ends a stuck command with rsp_err.
module mem_cmd_sequencer
   import mem_cmd_sequencer_pkg::*;
#(
   parameter int ADDR_W         = MEMORY_ADDR_WIDTH,
   parameter int DATA_W         = MEMORY_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   // Request channel: transfer on a posedge with req_valid && req_ready; the response is a
   // single-cycle rsp_valid pulse with no backpressure, and at most one request is in flight.
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_err,
   output logic [1:0]        mem_func,
   output logic              mem_execute,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic              mem_is_ready,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [ADDR_W-1:0] mem_free_addr,
   output logic [2:0]        dbg_state
);

   seq_state_t        state_q, state_d;
   logic [1:0]        op_q, op_d;
   logic              phase_q, phase_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              err_q, err_d;
   logic [1:0]        func_q, func_d;
   logic              timeout_hit;

`ifdef MEM_TIMEOUT_EN
   mem_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .run     (state_q == ST_WAIT_DONE),
      .expired (timeout_hit)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
   assign timeout_hit        = 1'b0;
`endif

   // After a reset the memory may still be finishing a command, so acceptance waits on is_ready.
   assign req_ready      = (state_q == ST_IDLE) && mem_is_ready && !rst;
   assign mem_execute    = (state_q == ST_ISSUE) && !rst;
   assign mem_func       = func_q;
   assign mem_address    = addr_q;
   assign mem_write_data = wdata_q;
   assign rsp_valid      = (state_q == ST_RESP);
   assign rsp_data       = rsp_valid ? data_q : '0;
   assign rsp_addr       = rsp_valid ? addr_q : '0;
   assign rsp_err        = rsp_valid && err_q;
   assign dbg_state      = state_q;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      phase_d = phase_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      data_d  = data_q;
      err_d   = err_q;
      func_d  = func_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               op_d    = req_op;
               wdata_d = req_wdata;
               data_d  = '0;
               err_d   = 1'b0;
               phase_d = 1'b0;
               func_d  = op_first_func(req_op);
               addr_d  = (req_op == OP_READ || req_op == OP_WRITE) ? req_addr : '0;
               if (req_op == OP_RSVD) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: state_d = ST_BLIND;
         // memory_unit's is_ready is not yet valid in the cycle after execute.
         ST_BLIND: state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (mem_is_ready) begin
               state_d = ST_RESP;
               if (op_q == OP_READ) begin
                  data_d = mem_read_data;
               end else if (op_q == OP_ALLOC && !phase_q) begin
                  addr_d = mem_free_addr;
                  if (mem_free_addr == '0) begin
                     err_d = 1'b1;
                  end else begin
                     phase_d = 1'b1;
                     func_d  = SET_CONTENTS;
                     state_d = ST_ISSUE;
                  end
               end
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               data_d  = '0;
               state_d = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_READ;
         phase_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         func_q  <= GET_CONTENTS;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         phase_q <= phase_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         data_q  <= data_d;
         err_q   <= err_d;
         func_q  <= func_d;
      end
   end

endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Bench for mem_cmd_sequencer: behavioural memory_unit stand-in plus a reference model of request results.
module tb_mem_cmd_sequencer;
   import mem_cmd_sequencer_pkg::*;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 64;
   localparam int TIMEOUT_CYCLES = 16;

   logic              clk, rst;
   logic              req_valid, req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid, rsp_err;
   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] rsp_addr;
   logic [1:0]        mem_func;
   logic              mem_execute, mem_is_ready;
   logic [ADDR_W-1:0] mem_address, mem_free_addr;
   logic [DATA_W-1:0] mem_write_data, mem_read_data;
   logic [2:0]        dbg_state;

   int checks = 0;
   int errors = 0;

   mem_cmd_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_err(rsp_err),
      .mem_func(mem_func), .mem_execute(mem_execute), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_is_ready(mem_is_ready),
      .mem_read_data(mem_read_data), .mem_free_addr(mem_free_addr), .dbg_state(dbg_state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory_unit stand-in: data commands busy 2 cycles, GET_FREE busy 1, plus optional extra delay
   logic [DATA_W-1:0] mem [int];
   logic [ADDR_W-1:0] free_ptr;
   logic [DATA_W-1:0] rd_q;
   logic [ADDR_W-1:0] free_q;
   int  busy;
   int  extra_delay = 0;
   bit  stub_nil = 0, stub_hang = 0, mem_init = 1;

   assign mem_is_ready  = (busy == 0) && !stub_hang;
   assign mem_read_data = rd_q;
   assign mem_free_addr = free_q;

   always @(posedge clk) begin
      if (mem_init) begin
         free_ptr <= 10'h100;
         busy     <= 0;
         rd_q     <= '0;
         free_q   <= '0;
         mem.delete();
      end else if (mem_execute) begin
         case (mem_func)
            GET_CONTENTS: begin
               rd_q <= mem.exists(int'(mem_address)) ? mem[int'(mem_address)] : '0;
               busy <= 2 + extra_delay;
            end
            SET_CONTENTS: begin
               mem[int'(mem_address)] = mem_write_data;
               busy <= 2 + extra_delay;
            end
            default: begin
               free_q <= stub_nil ? '0 : free_ptr;
               if (!stub_nil) free_ptr <= free_ptr + 1'b1;
               busy <= 1 + extra_delay;
            end
         endcase
      end else if (busy > 0) begin
         busy <= busy - 1;
      end
   end

   // reference model and scoreboard
   logic [DATA_W-1:0] ref_mem [int];
   logic [ADDR_W-1:0] ref_free = 10'h100;
   logic [DATA_W-1:0] exp_q[$];
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic              exp_err_q[$];

   task automatic run_req(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata);
      logic [DATA_W-1:0] e_data, g_data;
      logic [ADDR_W-1:0] e_addr, g_addr, hold_a;
      logic [DATA_W-1:0] hold_d;
      logic              e_err, g_err, got, have, prev;
      int                e_lat, lat, n;
      logic [1:0]        e_funcs[$], g_funcs[$];
      logic [ADDR_W-1:0] e_eaddr[$], g_eaddr[$];
      logic [DATA_W-1:0] g_wd[$];
      e_data = '0; e_addr = '0; e_err = 1'b0; e_lat = 1;
      case (op)
         OP_READ: begin
            e_data = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
            e_addr = addr; e_lat = 5;
            e_funcs.push_back(GET_CONTENTS); e_eaddr.push_back(addr);
         end
         OP_WRITE: begin
            ref_mem[int'(addr)] = wdata;
            e_addr = addr; e_lat = 5;
            e_funcs.push_back(SET_CONTENTS); e_eaddr.push_back(addr);
         end
         OP_ALLOC: begin
            e_funcs.push_back(GET_FREE); e_eaddr.push_back('0);
            if (stub_nil) begin
               e_err = 1'b1; e_lat = 4;  // GET_FREE phase of an 8-cycle alloc, then respond
            end else begin
               e_addr = ref_free; e_lat = 8;
               ref_mem[int'(ref_free)] = wdata;
               ref_free = ref_free + 1'b1;
               e_funcs.push_back(SET_CONTENTS); e_eaddr.push_back(e_addr);
            end
         end
         default: begin
            e_err = 1'b1; e_lat = 1;
         end
      endcase
      exp_q.push_back(e_data); exp_addr_q.push_back(e_addr); exp_err_q.push_back(e_err);

      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
      #1;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      checks++;
      if (!req_ready) begin
         errors++;
         $display("FAIL accept_timeout op=%0d req_ready=%b required 1", op, req_ready);
         req_valid = 1'b0;
         void'(exp_q.pop_front()); void'(exp_addr_q.pop_front()); void'(exp_err_q.pop_front());
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      req_op = 2'($urandom_range(0, 3)); req_addr = 10'($urandom); req_wdata = {$urandom, $urandom};

      lat = 0; got = 0; have = 0; prev = 0; hold_a = '0; hold_d = '0;
      g_data = '0; g_addr = '0; g_err = 1'b0;
      while (lat < 200) begin
         @(negedge clk); lat++;
         if (rsp_valid) begin
            got = 1; g_data = rsp_data; g_addr = rsp_addr; g_err = rsp_err;
            break;
         end
         if (mem_execute) begin
            checks++;
            if (prev) begin
               errors++;
               $display("FAIL exec_consecutive op=%0d cycle=%0d execute=1 required 0", op, lat);
            end
            g_funcs.push_back(mem_func); g_eaddr.push_back(mem_address); g_wd.push_back(mem_write_data);
            hold_a = mem_address; hold_d = mem_write_data; have = 1;
         end else if (have) begin
            checks++;
            if (mem_address !== hold_a || mem_write_data !== hold_d) begin
               errors++;
               $display("FAIL mem_hold op=%0d addr=%h/%h data=%h required %h/%h",
                        op, mem_address, hold_a, mem_write_data, hold_d, hold_a);
            end
         end
         prev = mem_execute;
      end

      e_data = exp_q.pop_front(); e_addr = exp_addr_q.pop_front(); e_err = exp_err_q.pop_front();
      checks++;
      if (got !== 1'b1) begin
         errors++;
         $display("FAIL rsp_missing op=%0d rsp_valid=0 required 1", op);
         return;
      end
      checks++;
      if (lat != e_lat) begin
         errors++; $display("FAIL latency op=%0d got %0d required %0d", op, lat, e_lat);
      end
      checks++;
      if (g_data !== e_data || g_addr !== e_addr || g_err !== e_err) begin
         errors++;
         $display("FAIL rsp_fields op=%0d data=%h addr=%h err=%b required data=%h addr=%h err=%b",
                  op, g_data, g_addr, g_err, e_data, e_addr, e_err);
      end
      checks++;
      if (g_funcs.size() != e_funcs.size()) begin
         errors++;
         $display("FAIL exec_count op=%0d got %0d required %0d", op, g_funcs.size(), e_funcs.size());
      end else begin
         for (int i = 0; i < e_funcs.size(); i++) begin
            checks++;
            if (g_funcs[i] !== e_funcs[i] ||
                (e_funcs[i] != GET_FREE && g_eaddr[i] !== e_eaddr[i]) ||
                (e_funcs[i] == SET_CONTENTS && g_wd[i] !== wdata)) begin
               errors++;
               $display("FAIL exec_cmd op=%0d idx=%0d func=%0d addr=%h wd=%h required func=%0d addr=%h wd=%h",
                        op, i, g_funcs[i], g_eaddr[i], g_wd[i], e_funcs[i], e_eaddr[i], wdata);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL rsp_pulse op=%0d rsp_valid=%b required 0", op, rsp_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_init = 1; req_valid = 1'b0;
      req_op = OP_READ; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      mem_init = 0;
      @(negedge clk);
      checks++;
      if ({req_ready, rsp_valid, rsp_err, mem_execute} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags ready/valid/err/exec=%b required 0000",
                  {req_ready, rsp_valid, rsp_err, mem_execute});
      end
      checks++;
      if (rsp_data !== '0 || rsp_addr !== '0 || mem_address !== '0 || mem_write_data !== '0) begin
         errors++;
         $display("FAIL reset_data rsp_data=%h rsp_addr=%h mem_addr=%h mem_wd=%h required 0",
                  rsp_data, rsp_addr, mem_address, mem_write_data);
      end
      checks++;
      if (mem_func !== GET_CONTENTS) begin
         errors++; $display("FAIL reset_func got %0d required %0d", mem_func, GET_CONTENTS);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++; $display("FAIL idle_ready got %b required 1", req_ready);
      end
   endtask

   task automatic test_directed();
      run_req(OP_WRITE, 10'h005, 64'hDEAD);
      run_req(OP_READ,  10'h005, 64'h0);
      run_req(OP_ALLOC, 10'h3FF, 64'h1234);
      run_req(OP_ALLOC, 10'h000, 64'h5678);
      run_req(OP_READ,  10'h100, 64'h0);
      run_req(OP_READ,  10'h101, 64'h0);
   endtask

   task automatic test_reserved();
      run_req(OP_RSVD, 10'h055, 64'hFFFF);
      run_req(OP_READ, 10'h005, 64'h0);
   endtask

   task automatic test_nil_alloc();
      stub_nil = 1;
      run_req(OP_ALLOC, 10'h000, 64'hBAD);
      stub_nil = 0;
   endtask

   task automatic test_back_to_back();
      logic [1:0]        op;
      logic [ADDR_W-1:0] a;
      int                r;
      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 9);
         op = (r < 4) ? OP_READ : (r < 7) ? OP_WRITE : (r < 9) ? OP_ALLOC : OP_RSVD;
         a  = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 31)) : 10'(10'h100 + $urandom_range(0, 7));
         run_req(op, a, {$urandom, $urandom});
      end
   endtask

   task automatic test_reset_mid();
      int n;
      bit saw_busy;
      extra_delay = 6;
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_READ; req_addr = 10'h005; req_wdata = '0;
      #1;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk); #1; n++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (mem_execute !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_outputs exec=%b ready=%b required 0/0", mem_execute, req_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      extra_delay = 0;
      saw_busy = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (!mem_is_ready) saw_busy = 1;
         checks++;
         if (rsp_valid !== 1'b0 || mem_execute !== 1'b0 || req_ready !== mem_is_ready) begin
            errors++;
            $display("FAIL rst_mid_idle cyc=%0d rsp_valid=%b exec=%b ready=%b required 0/0/%b",
                     i, rsp_valid, mem_execute, req_ready, mem_is_ready);
         end
      end
      checks++;
      if (!saw_busy) begin
         errors++; $display("FAIL rst_mid_busy memory busy after reset=0 required 1");
      end
      run_req(OP_READ, 10'h005, 64'h0);
   endtask

   task automatic test_timeout();
      int  lat;
      bit  got;
      logic [DATA_W-1:0] e_data;
      e_data = ref_mem.exists(32'h100) ? ref_mem[32'h100] : '0;
      @(negedge clk);
      req_valid = 1'b1; req_op = OP_READ; req_addr = 10'h100; req_wdata = '0;
      #1;
      lat = 0;
      while (!req_ready && lat < 100) begin
         @(negedge clk); #1; lat++;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      stub_hang = 1;
      lat = 0; got = 0;
      while (lat < 60) begin
         @(negedge clk); lat++;
         if (rsp_valid) begin got = 1; break; end
      end
`ifdef MEM_TIMEOUT_EN
      checks++;
      if (!got || lat != 2 + TIMEOUT_CYCLES + 1 || rsp_err !== 1'b1 || rsp_data !== '0) begin
         errors++;
         $display("FAIL timeout_rsp got=%b lat=%0d err=%b data=%h required 1/%0d/1/0",
                  got, lat, rsp_err, rsp_data, 2 + TIMEOUT_CYCLES + 1);
      end
      stub_hang = 0;
`else
      checks++;
      if (got) begin
         errors++; $display("FAIL no_timeout rsp_valid=1 at cycle %0d required none", lat);
      end
      stub_hang = 0;
      lat = 0; got = 0;
      while (lat < 10) begin
         @(negedge clk); lat++;
         if (rsp_valid) begin got = 1; break; end
      end
      checks++;
      if (!got || rsp_err !== 1'b0 || rsp_data !== e_data || rsp_addr !== 10'h100) begin
         errors++;
         $display("FAIL hang_release got=%b err=%b data=%h addr=%h required 1/0/%h/100",
                  got, rsp_err, rsp_data, rsp_addr, e_data);
      end
`endif
      run_req(OP_READ, 10'h100, 64'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_reserved();
      test_nil_alloc();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
